// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared widths and complex-bin type for the FFT spectrum path.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int DATA_W   = 16;
    localparam int BIN_W    = 9;
    localparam int NUM_BINS = 512;

    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } cplx_t;

endpackage
`default_nettype wire

// File: rtl/fft_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_tracker
// Purpose  : Running per-frame maximum with a one-cycle result pulse at frame end.
// Revision : 1.0
// ============================================================================
module fft_peak_tracker
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int BIN_W  = fft_pkg::BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mag_data,
    input  logic [BIN_W-1:0]  mag_bin,
    input  logic              mag_valid,
    input  logic              mag_last,
    output logic [DATA_W-1:0] peak_mag,
    output logic [BIN_W-1:0]  peak_bin,
    output logic              peak_valid
);

    logic [DATA_W-1:0] r_run_mag;
    logic [BIN_W-1:0]  r_run_bin;
    logic              r_empty;

    logic              w_take;
    logic [DATA_W-1:0] w_best_mag;
    logic [BIN_W-1:0]  w_best_bin;

    // Strict compare keeps the lowest bin on ties.
    assign w_take     = r_empty || (mag_data > r_run_mag);
    assign w_best_mag = w_take ? mag_data : r_run_mag;
    assign w_best_bin = w_take ? mag_bin  : r_run_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_mag  <= '0;
            r_run_bin  <= '0;
            r_empty    <= 1'b1;
            peak_mag   <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (mag_valid) begin
                if (mag_last) begin
                    peak_mag   <= w_best_mag;
                    peak_bin   <= w_best_bin;
                    peak_valid <= 1'b1;
                    r_empty    <= 1'b1;
                end else begin
                    r_run_mag  <= w_best_mag;
                    r_run_bin  <= w_best_bin;
                    r_empty    <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : fft_magnitude
// Purpose  : 3-stage alpha-max-plus-beta-min magnitude (1, 3/8) with frame peak.
// Revision : 1.0
// ============================================================================
module fft_magnitude
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int BIN_W  = fft_pkg::BIN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic [DATA_W-1:0]   mag_data,
    output logic [BIN_W-1:0]    mag_bin,
    output logic                mag_valid,
    output logic                mag_last,
    output logic [DATA_W-1:0]   peak_mag,
    output logic [BIN_W-1:0]    peak_bin,
    output logic                peak_valid
);

    localparam logic [DATA_W-1:0] c_data_one = 1;
    localparam logic [BIN_W-1:0]  c_bin_one  = 1;

    logic [DATA_W-1:0] w_re;
    logic [DATA_W-1:0] w_im;
    logic [DATA_W-1:0] w_abs_re;
    logic [DATA_W-1:0] w_abs_im;

    logic [BIN_W-1:0]  r_bin_cnt;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [BIN_W-1:0]  r_s1_bin;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;

    logic              r_s2_valid;
    logic              r_s2_last;
    logic [BIN_W-1:0]  r_s2_bin;
    logic [DATA_W-1:0] r_s2_mx;
    logic [DATA_W-1:0] r_s2_mn;

    assign w_re = in_data[DATA_W-1:0];
    assign w_im = in_data[2*DATA_W-1:DATA_W];

    // Two's-complement negate; the most negative input lands on 2^(DATA_W-1) unsigned.
    assign w_abs_re = w_re[DATA_W-1] ? (~w_re + c_data_one) : w_re;
    assign w_abs_im = w_im[DATA_W-1] ? (~w_im + c_data_one) : w_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bin   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_mx    <= '0;
            r_s2_mn    <= '0;
            mag_valid  <= 1'b0;
            mag_last   <= 1'b0;
            mag_bin    <= '0;
            mag_data   <= '0;
        end else begin
            if (in_valid) begin
                r_bin_cnt <= in_last ? '0 : (r_bin_cnt + c_bin_one);
            end

            r_s1_valid <= in_valid;
            r_s1_last  <= in_valid && in_last;
            r_s1_bin   <= r_bin_cnt;
            r_s1_a     <= w_abs_re;
            r_s1_b     <= w_abs_im;

            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_bin   <= r_s1_bin;
            r_s2_mx    <= (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
            r_s2_mn    <= (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;

            mag_valid  <= r_s2_valid;
            mag_last   <= r_s2_last;
            mag_bin    <= r_s2_bin;
            mag_data   <= r_s2_mx + (r_s2_mn >> 2) + (r_s2_mn >> 3);
        end
    end

    fft_peak_tracker #(
        .DATA_W (DATA_W),
        .BIN_W  (BIN_W)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .mag_data   (mag_data),
        .mag_bin    (mag_bin),
        .mag_valid  (mag_valid),
        .mag_last   (mag_last),
        .peak_mag   (peak_mag),
        .peak_bin   (peak_bin),
        .peak_valid (peak_valid)
    );

endmodule
`default_nettype wire

// File: doc/fft_magnitude.md
Name: fft_magnitude

Overview:
- Streaming magnitude stage that sits directly downstream of the FFT half-spectrum bin filter and upstream of the spectrum display/peak logic.
- Consumes packed complex bins (real in [15:0], imag in [31:16], two's complement) and emits an approximate unsigned magnitude per bin using alpha-max-plus-beta-min (alpha=1, beta=3/8).
- Also tracks the largest bin of each frame and reports its magnitude and index when the frame ends.
- No backpressure: the upstream stream is accepted every cycle that in_valid is high.

Parameters:
- DATA_W, 16, width of each real/imag component and of the output magnitude.
- BIN_W, 9, width of the bin index (512 bins per frame).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_data  input  2*DATA_W  packed complex bin; [DATA_W-1:0] real, [2*DATA_W-1:DATA_W] imag
- in_valid  input  1  in_data valid this cycle
- in_last  input  1  final bin of frame; qualified by in_valid
- mag_data  output  DATA_W  unsigned approximate magnitude
- mag_bin  output  BIN_W  bin index of mag_data within frame
- mag_valid  output  1  mag_data/mag_bin valid
- mag_last  output  1  final bin of frame, aligned with mag_valid
- peak_mag  output  DATA_W  largest magnitude of the completed frame
- peak_bin  output  BIN_W  bin index of peak_mag
- peak_valid  output  1  one-cycle pulse; peak_* valid

Behaviour:
- Reset: clk and rst as decided above (synchronous, active-high). All outputs 0; pipeline valid bits, bin counter and running peak cleared.
- Pipeline, 3 stages, fixed latency 3: input sample at cycle N appears on mag_* at cycle N+3. Bubbles propagate; valid/last/bin are delayed alongside the data.
- Stage 1: a = |re|, b = |im| as DATA_W-bit unsigned. -32768 maps to 32768 (fits unsigned 16 bits, no saturation). Bin index captured from the counter.
- Stage 2: mx = max(a,b), mn = min(a,b). On equality, either assignment (results identical).
- Stage 3: mag = mx + (mn>>2) + (mn>>3). Maximum is 32768+8192+4096 = 45056, which fits DATA_W unsigned; no overflow handling needed.
- Bin counter (BIN_W bits): increments on each in_valid. Returns to 0 on in_valid && in_last. Without last it wraps 511->0 naturally, and frames without last are not flagged.
- Peak tracker, operating on stage-3 output:
  - On mag_valid, if the sample is the first of a frame (the running-peak-empty flag is set) or mag > running_peak, update running_peak and running_bin. Strict greater-than, so on ties the lowest bin wins.
  - On mag_valid && mag_last: peak_mag/peak_bin take the final result including the last sample. They are registered, so peak_valid pulses on the cycle after mag_last. The running peak is then cleared to empty.
  - peak_mag/peak_bin hold their values until the next frame's pulse.
- Single-bin frame (in_last on the first sample): peak equals that sample's magnitude; peak_bin = 0.
- Back-to-back frames with no idle cycle: the new frame's first bin seeds the peak cleanly, with no carry-over from the previous frame.
- rst mid-frame: pipeline contents dropped, counter to 0, running peak empty. No peak_valid for the partial frame.

Decomposition:
- Package fft_pkg: DATA_W, BIN_W, NUM_BINS=512, and the typedef cplx_t (packed struct {logic signed [15:0] im; logic signed [15:0] re;}). The bin filter and this block share it.
- One sub-module, fft_peak_tracker (running max + frame pulse), kept separate so the display path can reuse it.
- The magnitude pipeline stays in the top level.

Test Plan:
- Single bin re=1000, im=-400, valid+last -> 3 cycles later mag_data=1150, mag_bin=0, mag_last=1; next cycle peak_valid=1, peak_mag=1150, peak_bin=0.
- re=-32768, im=-32768 -> mag_data=45056 (0xB000); no wrap.
- 512-bin frame with bin k = (re=k, im=0), then bin 300 overwritten with re=5000 -> mag_bin 0..511 in order, mag_last on bin 511, peak_mag=5000, peak_bin=300.
- Two equal maxima (re=2000) at bins 10 and 50 -> peak_bin=10.
- Back-to-back frames: frame A peak 900 at bin 5, frame B peak 40 at bin 2, no gap -> two peak_valid pulses, reporting (900,5) then (40,2).
- in_valid toggled 1,0,1,0 with rst asserted mid-frame -> no mag_valid from pre-reset samples after the reset cycle, no peak_valid; the next frame starts at bin 0.
